// File: rtl/psum_bank_scheduler.sv
// Partial-sum bank manager: allocates small/big psum banks per stage, steers write/read
// bank and address for every beat across reduction passes, and retains the result bank.
module psum_bank_scheduler #(
  parameter int SMALL_BANK_COUNT   = 3,
  parameter int BIG_BANK_COUNT     = 3,
  parameter int SMALL_THRESHOLD    = 16,
  parameter int ADDR_WIDTH         = 8,
  parameter int GPR_WIDTH          = 6,
  localparam int TOTAL_BANK_COUNT  = SMALL_BANK_COUNT + BIG_BANK_COUNT,
  localparam int BANK_INDEX_WIDTH  = $clog2(TOTAL_BANK_COUNT)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        stage_valid_i,
  output logic                        stage_ready_o,
  input  logic [ADDR_WIDTH-1:0]       seq1_length_i,
  input  logic [GPR_WIDTH-1:0]        seq2_length_i,
  input  logic [GPR_WIDTH-1:0]        operation_id_i,
  input  logic                        acc_mode_i,
  input  logic                        write_enable_i,
  output logic [BANK_INDEX_WIDTH-1:0] write_bank_index_o,
  output logic [ADDR_WIDTH-1:0]       write_address_o,
  output logic [BANK_INDEX_WIDTH-1:0] read_bank_index_o,
  output logic [ADDR_WIDTH-1:0]       read_address_o,
  output logic                        read_bank_valid_o,
  output logic                        stall_o,
  output logic                        busy_o,
  output logic                        done_valid_o,
  output logic [GPR_WIDTH-1:0]        done_op_id_o,
  output logic [BANK_INDEX_WIDTH-1:0] done_bank_index_o,
  input  logic                        release_valid_i,
  input  logic [BANK_INDEX_WIDTH-1:0] release_bank_index_i,
  output logic [TOTAL_BANK_COUNT-1:0] bank_busy_o
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALLOC = 3'd1,
    ST_PASS  = 3'd2,
    ST_TURN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                       state_q;
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             beat_cnt_q;
  logic [GPR_WIDTH-1:0]         passes_q;
  logic [GPR_WIDTH-1:0]         pass_cnt_q;
  logic [GPR_WIDTH-1:0]         op_id_q;
  logic                         mode_q;
  logic                         big_q;
  logic [TOTAL_BANK_COUNT-1:0]  bank_busy_q, bank_busy_d;
  logic [TOTAL_BANK_COUNT-1:0]  active_q, active_d;
  logic [GPR_WIDTH-1:0]         tag_q [TOTAL_BANK_COUNT];
  logic [BANK_INDEX_WIDTH-1:0]  write_bank_q;
  logic [BANK_INDEX_WIDTH-1:0]  read_bank_q;
  logic [ADDR_WIDTH-1:0]        write_address_q;
  logic                         read_bank_valid_q;
  logic                         stall_q;
  logic                         done_valid_q;
  logic [GPR_WIDTH-1:0]         done_op_id_q;
  logic [BANK_INDEX_WIDTH-1:0]  done_bank_q;

  logic [TOTAL_BANK_COUNT-1:0]  free_mask;
  logic                         small_found, big_found, sel_found;
  logic [BANK_INDEX_WIDTH-1:0]  small_idx, big_idx, sel_idx;
  logic                         class_single;
  logic                         inplace_turn;
  logic                         last_beat, last_pass;
  logic                         alloc_go, free_read, release_ok;

  generate
    for (genvar gi = 0; gi < TOTAL_BANK_COUNT; gi++) begin : g_free
      assign free_mask[gi] = ~bank_busy_q[gi];
    end
  endgenerate

  // Descending scan so the lowest free index of each class wins.
  always_comb begin
    small_found = 1'b0;
    small_idx   = '0;
    big_found   = 1'b0;
    big_idx     = '0;
    for (int i = SMALL_BANK_COUNT - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        small_found = 1'b1;
        small_idx   = BANK_INDEX_WIDTH'(i);
      end
    end
    for (int i = TOTAL_BANK_COUNT - 1; i >= SMALL_BANK_COUNT; i--) begin
      if (free_mask[i]) begin
        big_found = 1'b1;
        big_idx   = BANK_INDEX_WIDTH'(i);
      end
    end
  end

  assign sel_found    = big_q ? big_found : small_found;
  assign sel_idx      = big_q ? big_idx : small_idx;
  assign class_single = big_q ? (BIG_BANK_COUNT == 1) : (SMALL_BANK_COUNT == 1);
  assign inplace_turn = mode_q | class_single;
  assign last_beat    = (beat_cnt_q + LEN_W'(1)) == len_q;
  assign last_pass    = (pass_cnt_q + GPR_WIDTH'(1)) == passes_q;

  assign alloc_go   = ((state_q == ST_ALLOC) || (state_q == ST_TURN && !inplace_turn)) && sel_found;
  assign free_read  = (state_q == ST_PASS) && write_enable_i && last_beat && !mode_q &&
                      read_bank_valid_q && (read_bank_q != write_bank_q);
  assign release_ok = release_valid_i &&
                      (int'(release_bank_index_i) < TOTAL_BANK_COUNT) &&
                      bank_busy_q[release_bank_index_i] && !active_q[release_bank_index_i];

  // Banks held by the running stage are protected from release until it leaves DONE.
  always_comb begin
    bank_busy_d = bank_busy_q;
    active_d    = active_q;
    if (release_ok) begin
      bank_busy_d[release_bank_index_i] = 1'b0;
    end
    if (alloc_go) begin
      bank_busy_d[sel_idx] = 1'b1;
      active_d[sel_idx]    = 1'b1;
    end
    if (free_read) begin
      bank_busy_d[read_bank_q] = 1'b0;
      active_d[read_bank_q]    = 1'b0;
    end
    if (state_q == ST_DONE) begin
      active_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q           <= ST_IDLE;
      len_q             <= '0;
      beat_cnt_q        <= '0;
      passes_q          <= '0;
      pass_cnt_q        <= '0;
      op_id_q           <= '0;
      mode_q            <= 1'b0;
      big_q             <= 1'b0;
      bank_busy_q       <= '0;
      active_q          <= '0;
      for (int i = 0; i < TOTAL_BANK_COUNT; i++) tag_q[i] <= '0;
      write_bank_q      <= '0;
      read_bank_q       <= '0;
      write_address_q   <= '0;
      read_bank_valid_q <= 1'b0;
      stall_q           <= 1'b0;
      done_valid_q      <= 1'b0;
      done_op_id_q      <= '0;
      done_bank_q       <= '0;
    end else begin
      bank_busy_q  <= bank_busy_d;
      active_q     <= active_d;
      done_valid_q <= 1'b0;
      if (alloc_go) begin
        tag_q[sel_idx] <= op_id_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (stage_valid_i) begin
            len_q    <= (seq1_length_i == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, seq1_length_i};
            big_q    <= (seq1_length_i == '0) || (int'(seq1_length_i) >= SMALL_THRESHOLD);
            passes_q <= (seq2_length_i == '0) ? GPR_WIDTH'(1) : seq2_length_i;
            op_id_q  <= operation_id_i;
            mode_q   <= acc_mode_i;
            stall_q  <= 1'b1;
            state_q  <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (sel_found) begin
            write_bank_q      <= sel_idx;
            write_address_q   <= '0;
            beat_cnt_q        <= '0;
            pass_cnt_q        <= '0;
            read_bank_valid_q <= 1'b0;
            stall_q           <= 1'b0;
            state_q           <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (write_enable_i) begin
            if (last_beat) begin
              write_address_q <= '0;
              beat_cnt_q      <= '0;
              if (last_pass) begin
                done_valid_q      <= 1'b1;
                done_op_id_q      <= tag_q[write_bank_q];
                done_bank_q       <= write_bank_q;
                read_bank_valid_q <= 1'b0;
                state_q           <= ST_DONE;
              end else begin
                pass_cnt_q <= pass_cnt_q + GPR_WIDTH'(1);
                stall_q    <= 1'b1;
                state_q    <= ST_TURN;
              end
            end else begin
              write_address_q <= write_address_q + ADDR_WIDTH'(1);
              beat_cnt_q      <= beat_cnt_q + LEN_W'(1);
            end
          end
        end
        ST_TURN: begin
          write_address_q <= '0;
          if (inplace_turn) begin
            read_bank_q       <= write_bank_q;
            read_bank_valid_q <= 1'b1;
            stall_q           <= 1'b0;
            state_q           <= ST_PASS;
          end else if (sel_found) begin
            read_bank_q       <= write_bank_q;
            write_bank_q      <= sel_idx;
            read_bank_valid_q <= 1'b1;
            stall_q           <= 1'b0;
            state_q           <= ST_PASS;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stage_ready_o      = (state_q == ST_IDLE);
  assign busy_o             = (state_q != ST_IDLE);
  assign write_bank_index_o = write_bank_q;
  assign write_address_o    = write_address_q;
  assign read_bank_index_o  = read_bank_q;
  assign read_address_o     = write_address_q;
  assign read_bank_valid_o  = read_bank_valid_q;
  assign stall_o            = stall_q;
  assign done_valid_o       = done_valid_q;
  assign done_op_id_o       = done_op_id_q;
  assign done_bank_index_o  = done_bank_q;
  assign bank_busy_o        = bank_busy_q;

endmodule

// File: tb/tb_psum_bank_scheduler.sv
// Scoreboard bench: driver pushes expected beats/completions, a negedge monitor pops and compares.
module tb_psum_bank_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       stage_valid_i = 1'b0;
  logic       stage_ready_o;
  logic [7:0] seq1_length_i = '0;
  logic [5:0] seq2_length_i = '0;
  logic [5:0] operation_id_i = '0;
  logic       acc_mode_i = 1'b0;
  logic       write_enable_i = 1'b0;
  logic [2:0] write_bank_index_o;
  logic [7:0] write_address_o;
  logic [2:0] read_bank_index_o;
  logic [7:0] read_address_o;
  logic       read_bank_valid_o;
  logic       stall_o;
  logic       busy_o;
  logic       done_valid_o;
  logic [5:0] done_op_id_o;
  logic [2:0] done_bank_index_o;
  logic       release_valid_i = 1'b0;
  logic [2:0] release_bank_index_i = '0;
  logic [5:0] bank_busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_done;
    int wbank;
    int addr;
    bit rvalid;
    int rbank;
    int opid;
    int mask;
  } exp_t;

  exp_t sbq[$];

  psum_bank_scheduler dut (
    .clk_i               (clk_i),
    .reset_ni            (reset_ni),
    .stage_valid_i       (stage_valid_i),
    .stage_ready_o       (stage_ready_o),
    .seq1_length_i       (seq1_length_i),
    .seq2_length_i       (seq2_length_i),
    .operation_id_i      (operation_id_i),
    .acc_mode_i          (acc_mode_i),
    .write_enable_i      (write_enable_i),
    .write_bank_index_o  (write_bank_index_o),
    .write_address_o     (write_address_o),
    .read_bank_index_o   (read_bank_index_o),
    .read_address_o      (read_address_o),
    .read_bank_valid_o   (read_bank_valid_o),
    .stall_o             (stall_o),
    .busy_o              (busy_o),
    .done_valid_o        (done_valid_o),
    .done_op_id_o        (done_op_id_o),
    .done_bank_index_o   (done_bank_index_o),
    .release_valid_i     (release_valid_i),
    .release_bank_index_i(release_bank_index_i),
    .bank_busy_o         (bank_busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // Monitor: one line per observed transaction.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (done_valid_o) begin
        if (sbq.size() == 0 || !sbq[0].is_done) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=op%0d required=none", done_op_id_o);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          $display("done op=%0d bank=%0d mask=%b", done_op_id_o, done_bank_index_o, bank_busy_o);
          chk("done_op_id", 32'(done_op_id_o), e.opid);
          chk("done_bank", 32'(done_bank_index_o), e.wbank);
          chk("done_mask", 32'(bank_busy_o), e.mask);
          chk("done_rvalid", 32'(read_bank_valid_o), 0);
        end
      end else if (write_enable_i && busy_o && !stall_o) begin
        if (sbq.size() == 0 || sbq[0].is_done) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=addr%0d required=none", write_address_o);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          $display("beat wb=%0d addr=%0d rv=%0d rb=%0d", write_bank_index_o, write_address_o,
                   read_bank_valid_o, read_bank_index_o);
          chk("beat_wbank", 32'(write_bank_index_o), e.wbank);
          chk("beat_addr", 32'(write_address_o), e.addr);
          chk("beat_raddr", 32'(read_address_o), e.addr);
          chk("beat_rvalid", 32'(read_bank_valid_o), 32'(e.rvalid));
          if (e.rvalid) chk("beat_rbank", 32'(read_bank_index_o), e.rbank);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_running();
    int n = 0;
    while ((stall_o || !busy_o) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("wait_running_timeout", 32'(n), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("wait_idle_timeout", 32'(n), 0);
  endtask

  task automatic accept(int s1, int s2, int id, bit mode);
    int n = 0;
    while (!stage_ready_o && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("accept_timeout", 32'(n), 0);
    stage_valid_i  = 1'b1;
    seq1_length_i  = 8'(s1);
    seq2_length_i  = 6'(s2);
    operation_id_i = 6'(id);
    acc_mode_i     = mode;
    tick();
    stage_valid_i  = 1'b0;
  endtask

  task automatic release_bank(int b);
    release_valid_i      = 1'b1;
    release_bank_index_i = 3'(b);
    tick();
    release_valid_i      = 1'b0;
  endtask

  task automatic beat(int wb, int addr, bit rv, int rb);
    exp_t e;
    e.is_done = 0;
    e.wbank   = wb;
    e.addr    = addr;
    e.rvalid  = rv;
    e.rbank   = rb;
    e.opid    = 0;
    e.mask    = 0;
    sbq.push_back(e);
    write_enable_i = 1'b1;
    tick();
    write_enable_i = 1'b0;
  endtask

  // Pass p writes wa on even passes and wb on odd ones (ping-pong); in-place always wa.
  task automatic run_passes(int len, int np, int id, bit mode, int wa, int wb, int mask);
    for (int p = 0; p < np; p++) begin
      int wbank, rbank;
      wbank = (mode || (p % 2 == 0)) ? wa : wb;
      rbank = mode ? wa : ((p % 2 == 0) ? wb : wa);
      wait_running();
      for (int b = 0; b < len; b++) begin
        if (p == np - 1 && b == len - 1) begin
          exp_t d;
          sbq.push_back('{0, wbank, b, p > 0, rbank, 0, 0});
          d = '{1, wbank, 0, 0, 0, id, mask};
          sbq.push_back(d);
          write_enable_i = 1'b1;
          tick();
          write_enable_i = 1'b0;
        end else begin
          beat(wbank, b, p > 0, rbank);
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_bank_busy", 32'(bank_busy_o), 0);
    chk("rst_stage_ready", 32'(stage_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done_valid", 32'(done_valid_o), 0);
    chk("rst_write_address", 32'(write_address_o), 0);
    reset_ni = 1'b1;
    tick();

    // 1: small single pass
    accept(4, 1, 5, 0);
    run_passes(4, 1, 5, 0, 0, 0, 6'b000001);
    release_bank(0);
    chk("t1_mask_after_release", 32'(bank_busy_o), 0);

    // 2: big ping-pong, 3 passes; releases of an active bank and a free bank are ignored
    accept(20, 3, 7, 0);
    wait_running();
    release_bank(3);
    release_bank(5);
    chk("t2_release_ignored", 32'(bank_busy_o), 6'b001000);
    run_passes(20, 3, 7, 0, 3, 4, 6'b001000);
    release_bank(3);

    // 3: big in-place, 3 passes
    accept(20, 3, 9, 1);
    run_passes(20, 3, 9, 1, 3, 3, 6'b001000);
    release_bank(3);
    chk("t3_mask_after_release", 32'(bank_busy_o), 0);

    // 4: fill all small banks, fourth stage stalls until bank 1 is released
    accept(4, 1, 1, 0);
    run_passes(4, 1, 1, 0, 0, 0, 6'b000001);
    accept(4, 1, 2, 0);
    run_passes(4, 1, 2, 0, 1, 1, 6'b000011);
    accept(4, 1, 3, 0);
    run_passes(4, 1, 3, 0, 2, 2, 6'b000111);
    accept(4, 1, 4, 0);
    repeat (3) tick();
    chk("t4_alloc_stall", 32'(stall_o), 1);
    chk("t4_alloc_mask", 32'(bank_busy_o), 6'b000111);
    release_bank(1);
    chk("t4_stall_same_cycle", 32'(stall_o), 1);
    chk("t4_mask_released", 32'(bank_busy_o), 6'b000101);
    tick();
    chk("t4_alloc_after", 32'(stall_o), 0);
    run_passes(4, 1, 4, 0, 1, 1, 6'b000111);
    release_bank(0);
    release_bank(1);
    release_bank(2);
    chk("t4_all_released", 32'(bank_busy_o), 0);

    // 5: seq1=0 means 256 beats in a big bank; seq2=0 means a single pass
    accept(0, 0, 11, 0);
    run_passes(256, 1, 11, 0, 3, 4, 6'b001000);
    release_bank(3);

    // 6: reset in the middle of the first pass of a two-pass op
    accept(4, 2, 12, 0);
    wait_running();
    beat(0, 0, 0, 0);
    beat(0, 1, 0, 0);
    reset_ni = 1'b0;
    #2;
    chk("t6_bank_busy", 32'(bank_busy_o), 0);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_stall", 32'(stall_o), 0);
    chk("t6_write_address", 32'(write_address_o), 0);
    chk("t6_done_valid", 32'(done_valid_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    repeat (3) tick();
    chk("t6_stage_ready", 32'(stage_ready_o), 1);
    chk("t6_bank_busy_after", 32'(bank_busy_o), 0);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
